// File: rtl/any1_lane_aligner_pkg.sv
// Shared types and bus geometry for the any1 lane aligner: the 32-byte line
// size, the FSM state encoding and a small state-class helper.
package any1_pkg;

  localparam int BUS_BYTES = 32;
  localparam int BUS_BITS  = BUS_BYTES * 8;
  localparam int OFF_W     = $clog2(BUS_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    CYC1,
    GAP,
    CYC2,
    RESP
  } AlignState;

  // True while the bus cycle is held open, including the gap between beats.
  function automatic logic in_bus_cycle(input AlignState s);
    return (s == CYC1) || (s == GAP) || (s == CYC2);
  endfunction

endpackage

// File: rtl/any1_lane_aligner_if.sv
// Request-side and Wishbone-side bundles of the lane aligner. Signal names keep
// their port-level _i/_o suffixes as seen from the aligner.
interface any1_req_if #(
  parameter int AWID = 32
);
  import any1_pkg::*;

  logic                 req_valid_i;
  logic                 req_ready_o;
  logic                 req_we_i;
  logic [AWID-1:0]      req_adr_i;
  logic [BUS_BYTES-1:0] req_sel_i;
  logic [BUS_BITS-1:0]  req_dat_i;
  logic                 resp_valid_o;
  logic                 resp_err_o;
  logic [BUS_BITS-1:0]  resp_dat_o;

  modport master (
    output req_valid_i, req_we_i, req_adr_i, req_sel_i, req_dat_i,
    input  req_ready_o, resp_valid_o, resp_err_o, resp_dat_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_adr_i, req_sel_i, req_dat_i,
    output req_ready_o, resp_valid_o, resp_err_o, resp_dat_o
  );
endinterface

interface any1_wb_if #(
  parameter int AWID = 32
);
  import any1_pkg::*;

  logic                 cyc_o;
  logic                 stb_o;
  logic                 we_o;
  logic [BUS_BYTES-1:0] sel_o;
  logic [AWID-1:0]      adr_o;
  logic [BUS_BITS-1:0]  dat_o;
  logic                 ack_i;
  logic                 err_i;
  logic [BUS_BITS-1:0]  dat_i;

  modport master (
    output cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
    input  ack_i, err_i, dat_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
    output ack_i, err_i, dat_i
  );
endinterface

// File: rtl/any1_lane_shift.sv
// Log-stage barrel shifter moving data in UNIT-bit steps, left or right; the
// output keeps the low OW bits of the shifted word.
module any1_lane_shift #(
  parameter int IW    = 512,
  parameter int OW    = 512,
  parameter int AMT_W = 5,
  parameter int UNIT  = 8,
  parameter bit RIGHT = 1'b0
) (
  input  logic [IW-1:0]    i_dat,
  input  logic [AMT_W-1:0] i_amt,
  output logic [OW-1:0]    o_dat
);

  logic [IW-1:0] w_work;

  // NOTE: combinational blocks use blocking '=' so each stage sees the previous one.
  always_comb begin
    w_work = i_dat;
    for (int s = 0; s < AMT_W; s++) begin
      if (i_amt[s]) begin
        w_work = RIGHT ? (w_work >> (UNIT << s)) : (w_work << (UNIT << s));
      end
    end
  end

  assign o_dat = w_work[OW-1:0];

endmodule

// File: rtl/any1_lane_aligner.sv
// Lane aligner: shifts a right-justified request into bus lanes, issues one or
// two Wishbone-classic beats across a 32-byte line, and right-justifies loads.
module any1_lane_aligner
  import any1_pkg::*;
#(
  parameter int AWID = 32
) (
  input  logic      clk_i,
  input  logic      rst_i,
  any1_req_if.slave req,
  any1_wb_if.master wb
);

  localparam int LW = AWID - OFF_W;
  localparam logic [OFF_W-1:0] LINE_BASE = '0;

  AlignState r_state, w_next_state;

  logic [OFF_W-1:0]       r_off;
  logic [LW-1:0]          r_line;
  logic [BUS_BYTES-1:0]   r_sel_hi;
  logic [BUS_BITS-1:0]    r_dat_hi;
  logic [BUS_BITS-1:0]    r_lo;
  logic                   r_cyc, r_stb, r_we;
  logic [BUS_BYTES-1:0]   r_sel_o;
  logic [AWID-1:0]        r_adr_o;
  logic [BUS_BITS-1:0]    r_dat_o;
  logic                   r_resp_valid, r_resp_err;
  logic [BUS_BITS-1:0]    r_resp_dat;

  logic [2*BUS_BYTES-1:0] w_sel64;
  logic [2*BUS_BITS-1:0]  w_dat512;
  logic [BUS_BITS-1:0]    w_lo_in, w_hi_in, w_load;
  logic [LW-1:0]          w_req_line, w_req_line_next, w_line_next;
  logic                   w_accept, w_ack;

  any1_lane_shift #(
    .IW(2*BUS_BYTES), .OW(2*BUS_BYTES), .AMT_W(OFF_W), .UNIT(1), .RIGHT(1'b0)
  ) u_sel_shift (
    .i_dat({{BUS_BYTES{1'b0}}, req.req_sel_i}),
    .i_amt(req.req_adr_i[OFF_W-1:0]),
    .o_dat(w_sel64)
  );

  any1_lane_shift #(
    .IW(2*BUS_BITS), .OW(2*BUS_BITS), .AMT_W(OFF_W), .UNIT(8), .RIGHT(1'b0)
  ) u_st_shift (
    .i_dat({{BUS_BITS{1'b0}}, req.req_dat_i}),
    .i_amt(req.req_adr_i[OFF_W-1:0]),
    .o_dat(w_dat512)
  );

  // Read data is merged before shifting; the beat completing this cycle comes straight from dat_i.
  assign w_lo_in = (r_state == CYC1) ? wb.dat_i : r_lo;
  assign w_hi_in = (r_state == CYC2) ? wb.dat_i : {BUS_BITS{1'b0}};

  any1_lane_shift #(
    .IW(2*BUS_BITS), .OW(BUS_BITS), .AMT_W(OFF_W), .UNIT(8), .RIGHT(1'b1)
  ) u_ld_shift (
    .i_dat({w_hi_in, w_lo_in}),
    .i_amt(r_off),
    .o_dat(w_load)
  );

  assign w_accept        = (r_state == IDLE) && req.req_valid_i;
  assign w_ack           = wb.ack_i && !wb.err_i;
  assign w_req_line      = req.req_adr_i[AWID-1:OFF_W];
  assign w_req_line_next = w_req_line + LW'(1);
  assign w_line_next     = r_line + LW'(1);

  // NOTE: every path through this block starts from a default, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (req.req_valid_i) begin
          if (req.req_sel_i == '0)                  w_next_state = RESP;
          else if (w_sel64[BUS_BYTES-1:0] == '0)    w_next_state = CYC2;
          else                                      w_next_state = CYC1;
        end
      end
      CYC1: begin
        if (wb.err_i)   w_next_state = RESP;
        else if (w_ack) w_next_state = (r_sel_hi != '0) ? GAP : RESP;
      end
      GAP:  w_next_state = CYC2;
      CYC2: if (wb.err_i || wb.ack_i) w_next_state = RESP;
      RESP: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so all flops update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_off        <= '0;
      r_line       <= '0;
      r_sel_hi     <= '0;
      r_dat_hi     <= '0;
      r_lo         <= '0;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_sel_o      <= '0;
      r_adr_o      <= '0;
      r_dat_o      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_dat   <= '0;
    end else begin
      r_cyc        <= in_bus_cycle(w_next_state);
      r_stb        <= (w_next_state == CYC1) || (w_next_state == CYC2);
      r_resp_valid <= (w_next_state == RESP);

      if (w_accept) begin
        r_off    <= req.req_adr_i[OFF_W-1:0];
        r_line   <= w_req_line;
        r_sel_hi <= w_sel64[2*BUS_BYTES-1:BUS_BYTES];
        r_dat_hi <= w_dat512[2*BUS_BITS-1:BUS_BITS];
        r_lo     <= '0;
        r_we     <= req.req_we_i;
        if (w_sel64[BUS_BYTES-1:0] != '0) begin
          r_adr_o <= {w_req_line, LINE_BASE};
          r_sel_o <= w_sel64[BUS_BYTES-1:0];
          r_dat_o <= w_dat512[BUS_BITS-1:0];
        end else begin
          r_adr_o <= {w_req_line_next, LINE_BASE};
          r_sel_o <= w_sel64[2*BUS_BYTES-1:BUS_BYTES];
          r_dat_o <= w_dat512[2*BUS_BITS-1:BUS_BITS];
        end
      end

      // Beat 1 done: keep its read data and stage beat 2 on the bus outputs.
      if ((r_state == CYC1) && w_ack) begin
        r_lo    <= wb.dat_i;
        r_adr_o <= {w_line_next, LINE_BASE};
        r_sel_o <= r_sel_hi;
        r_dat_o <= r_dat_hi;
      end

      if (w_next_state == RESP) begin
        r_resp_err <= wb.err_i && ((r_state == CYC1) || (r_state == CYC2));
        r_resp_dat <= (r_state == IDLE) ? '0 : w_load;
      end
    end
  end

  assign req.req_ready_o  = (r_state == IDLE);
  assign req.resp_valid_o = r_resp_valid;
  assign req.resp_err_o   = r_resp_err;
  assign req.resp_dat_o   = r_resp_dat;
  assign wb.cyc_o         = r_cyc;
  assign wb.stb_o         = r_stb;
  assign wb.we_o          = r_we;
  assign wb.sel_o         = r_sel_o;
  assign wb.adr_o         = r_adr_o;
  assign wb.dat_o         = r_dat_o;

endmodule

// File: tb/tb_any1_lane_aligner.sv
// Directed bench for any1_lane_aligner: aligned/offset/split/wrapping requests,
// bus errors, empty selects and reset in the middle of a beat.
module tb_any1_lane_aligner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_beats = 0;
  int   n_resp = 0;

  always #5 clk = ~clk;

  any1_req_if #(.AWID(32)) u_req ();
  any1_wb_if  #(.AWID(32)) u_wb ();

  any1_lane_aligner #(.AWID(32)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req  (u_req),
    .wb   (u_wb)
  );

  always @(negedge clk) begin
    if (u_wb.cyc_o && u_wb.stb_o) n_beats++;
    if (u_req.resp_valid_o)       n_resp++;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] sel,
                       input logic [255:0] dat);
    u_req.req_we_i    = we;
    u_req.req_adr_i   = adr;
    u_req.req_sel_i   = sel;
    u_req.req_dat_i   = dat;
    u_req.req_valid_i = 1'b1;
    tick();
    u_req.req_valid_i = 1'b0;
  endtask

  initial begin
    logic [255:0] d1;
    logic [255:0] v;
    int b;
    d1 = 256'h0123456789ABCDEF_FEDCBA9876543210;

    u_req.req_valid_i = 1'b0;
    u_req.req_we_i    = 1'b0;
    u_req.req_adr_i   = '0;
    u_req.req_sel_i   = '0;
    u_req.req_dat_i   = '0;
    u_wb.ack_i        = 1'b0;
    u_wb.err_i        = 1'b0;
    u_wb.dat_i        = '0;

    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_ready", u_req.req_ready_o, 1);
    check("rst_cyc", u_wb.cyc_o, 0);
    check("rst_resp_valid", u_req.resp_valid_o, 0);
    check("rst_sel", u_wb.sel_o, 0);
    check("rst_adr", u_wb.adr_o, 0);

    // Aligned store, single beat.
    issue(1'b1, 32'h1000, 32'hFFFF, d1);
    check("st_cyc", u_wb.cyc_o, 1);
    check("st_stb", u_wb.stb_o, 1);
    check("st_we", u_wb.we_o, 1);
    check("st_adr", u_wb.adr_o, 32'h1000);
    check("st_sel", u_wb.sel_o, 32'h0000FFFF);
    check("st_dat", u_wb.dat_o, d1);
    check("st_busy", u_req.req_ready_o, 0);
    u_wb.ack_i = 1'b1; tick(); u_wb.ack_i = 1'b0;
    check("st_resp", u_req.resp_valid_o, 1);
    check("st_err", u_req.resp_err_o, 0);
    check("st_cyc_drop", u_wb.cyc_o, 0);
    tick();
    check("st_pulse", u_req.resp_valid_o, 0);
    check("st_ready", u_req.req_ready_o, 1);

    // Store at byte offset 4.
    issue(1'b1, 32'h1004, 32'hF, 256'hDEADBEEF);
    check("off_adr", u_wb.adr_o, 32'h1000);
    check("off_sel", u_wb.sel_o, 32'h000000F0);
    check("off_dat", u_wb.dat_o, 256'hDEADBEEF_00000000);
    u_wb.ack_i = 1'b1; tick(); u_wb.ack_i = 1'b0;
    check("off_resp", u_req.resp_valid_o, 1);
    tick();

    // Unsplit load at offset 8.
    issue(1'b0, 32'h2008, 32'hF, '0);
    check("ld_we", u_wb.we_o, 0);
    check("ld_adr", u_wb.adr_o, 32'h2000);
    check("ld_sel", u_wb.sel_o, 32'h00000F00);
    u_wb.dat_i = 256'hCAFEF00D_00000000_00000000;
    u_wb.ack_i = 1'b1; tick(); u_wb.ack_i = 1'b0; u_wb.dat_i = '0;
    check("ld_resp", u_req.resp_valid_o, 1);
    check("ld_dat", u_req.resp_dat_o[31:0], 32'hCAFEF00D);
    tick();

    // Split load across the 0x1000/0x1020 line boundary.
    issue(1'b0, 32'h101C, 32'hFF, '0);
    check("sp_b1_adr", u_wb.adr_o, 32'h1000);
    check("sp_b1_sel", u_wb.sel_o, 32'hF0000000);
    v = 256'h44332211;
    u_wb.dat_i = v << 224;
    u_wb.ack_i = 1'b1; tick(); u_wb.ack_i = 1'b0;
    check("sp_gap_cyc", u_wb.cyc_o, 1);
    check("sp_gap_stb", u_wb.stb_o, 0);
    tick();
    check("sp_b2_stb", u_wb.stb_o, 1);
    check("sp_b2_adr", u_wb.adr_o, 32'h1020);
    check("sp_b2_sel", u_wb.sel_o, 32'h0000000F);
    u_wb.dat_i = 256'h88776655;
    u_wb.ack_i = 1'b1; tick(); u_wb.ack_i = 1'b0; u_wb.dat_i = '0;
    check("sp_resp", u_req.resp_valid_o, 1);
    check("sp_dat", u_req.resp_dat_o[63:0], 64'h8877665544332211);
    tick();

    // Error on beat 1 of a split load aborts beat 2.
    b = n_beats;
    issue(1'b0, 32'h101C, 32'hFF, '0);
    u_wb.err_i = 1'b1; tick(); u_wb.err_i = 1'b0;
    check("e1_resp", u_req.resp_valid_o, 1);
    check("e1_err", u_req.resp_err_o, 1);
    check("e1_cyc", u_wb.cyc_o, 0);
    tick(); tick();
    check("e1_beats", n_beats - b, 1);
    check("e1_ready", u_req.req_ready_o, 1);

    // ack and err together: error wins.
    issue(1'b1, 32'h4000, 32'h1, 256'h5A);
    u_wb.dat_i = 256'hFF;
    u_wb.ack_i = 1'b1; u_wb.err_i = 1'b1; tick();
    u_wb.ack_i = 1'b0; u_wb.err_i = 1'b0; u_wb.dat_i = '0;
    check("ae_resp", u_req.resp_valid_o, 1);
    check("ae_err", u_req.resp_err_o, 1);
    tick();

    // Empty select: immediate response, no bus cycle.
    b = n_beats;
    issue(1'b0, 32'h3000, 32'h0, '0);
    check("z_resp", u_req.resp_valid_o, 1);
    check("z_err", u_req.resp_err_o, 0);
    check("z_dat", u_req.resp_dat_o, 0);
    check("z_cyc", u_wb.cyc_o, 0);
    tick();
    check("z_pulse", u_req.resp_valid_o, 0);
    check("z_beats", n_beats - b, 0);

    // Split store wrapping past the top line to address 0.
    issue(1'b1, 32'hFFFFFFFE, 32'hF, 256'hAABBCCDD);
    check("w_b1_adr", u_wb.adr_o, 32'hFFFFFFE0);
    check("w_b1_sel", u_wb.sel_o, 32'hC0000000);
    check("w_b1_dat", u_wb.dat_o[255:240], 16'hCCDD);
    u_wb.ack_i = 1'b1; tick(); u_wb.ack_i = 1'b0;
    tick();
    check("w_b2_adr", u_wb.adr_o, 32'h00000000);
    check("w_b2_sel", u_wb.sel_o, 32'h00000003);
    check("w_b2_dat", u_wb.dat_o[15:0], 16'hAABB);
    u_wb.ack_i = 1'b1; tick(); u_wb.ack_i = 1'b0;
    check("w_resp", u_req.resp_valid_o, 1);
    check("w_err", u_req.resp_err_o, 0);
    tick();

    // Reset during beat 2 with ack pending; a late ack must not complete anything.
    b = n_resp;
    issue(1'b0, 32'h101C, 32'hFF, '0);
    u_wb.ack_i = 1'b1; tick(); u_wb.ack_i = 1'b0;
    tick();
    check("r_in_cyc2", u_wb.stb_o, 1);
    u_wb.ack_i = 1'b1; rst = 1'b1; tick(); rst = 1'b0;
    check("r_cyc", u_wb.cyc_o, 0);
    check("r_stb", u_wb.stb_o, 0);
    check("r_resp", u_req.resp_valid_o, 0);
    check("r_ready", u_req.req_ready_o, 1);
    check("r_sel", u_wb.sel_o, 0);
    tick();
    u_wb.ack_i = 1'b0;
    tick();
    check("r_late_ack", n_resp - b, 0);
    check("r_idle_cyc", u_wb.cyc_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
